// File: rtl/servo_position_controller.sv
// Single-axis servo position controller: wrap-around error, bang-bang/proportional drive,
// encoder zeroing and settle detection. Optional duty slew limit: define SERVO_RAMP_EN.
module servo_position_controller #(
    parameter int ANGLE_W        = 12,
    parameter int COUNTS_PER_REV = 1006,
    parameter int DUTY_W         = 8,
    parameter int KP_SHIFT       = 0,
    parameter int DEADBAND       = 0,
    parameter int SETTLE_CYCLES  = 8,
    parameter int ZERO_CYCLES    = 4,
    parameter int RAMP_STEP      = 4
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ANGLE_W-1:0] cmd_angle,
    input  logic [DUTY_W-1:0]  cmd_period,
    input  logic [1:0]         cmd_mode,
    input  logic               cmd_power,
    input  logic [ANGLE_W-1:0] current_angle,
    output logic [DUTY_W-1:0]  pwm_period,
    output logic [DUTY_W-1:0]  pwm_duty,
    output logic               pwm_power,
    output logic               pwm_brake,
    output logic               clockwise,
    output logic               atu_reset,
    output logic               atu_monitor,
    output logic               at_target,
    output logic               cmd_error,
    output logic               busy
);
    localparam int ERR_W  = ANGLE_W + 2;
    localparam int HALF   = COUNTS_PER_REV / 2;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int ZCNT_W = (ZERO_CYCLES > 1) ? $clog2(ZERO_CYCLES) : 1;
    localparam logic signed [ERR_W-1:0] HALF_S = ERR_W'(HALF);
    localparam logic signed [ERR_W-1:0] CPR_S  = ERR_W'(COUNTS_PER_REV);
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [1:0] OP_SET = 2'b00, OP_ZERO = 2'b01, OP_RUN = 2'b10, OP_BRAKE = 2'b11;

    if (COUNTS_PER_REV > (1 << ANGLE_W) || SETTLE_CYCLES < 1 || ZERO_CYCLES < 1 || RAMP_STEP < 1)
    begin : g_param_check
        $error("servo_position_controller: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, ZERO} state_t;

    state_t                    state, state_next;
    logic [ZCNT_W-1:0]         zcnt, zcnt_next;
    logic [SCNT_W-1:0]         scnt, scnt_next;
    logic [ANGLE_W-1:0]        target;
    logic [1:0]                mode;
    logic                      reject, set_load, zero_done;
    logic signed [ERR_W-1:0]   err_raw_p0, err_p0;
    logic [ERR_W-1:0]          err_abs_p0;
    logic                      fault_p0, in_band_p0, drive_p0;
    logic [DUTY_W-1:0]         law_p0, duty_next_p0;

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [ERR_W-1:0] mag);
        logic [ERR_W+KP_SHIFT-1:0] scaled;
        scaled = (ERR_W+KP_SHIFT)'(mag) << KP_SHIFT;
        if (scaled > (ERR_W+KP_SHIFT)'(DUTY_MAX)) return DUTY_MAX;
        return scaled[DUTY_W-1:0];
    endfunction

`ifdef SERVO_RAMP_EN
    function automatic logic [DUTY_W-1:0] ramp_duty(input logic [DUTY_W-1:0] now,
                                                    input logic [DUTY_W-1:0] goal);
        logic [DUTY_W:0] step;
        step = (DUTY_W+1)'(RAMP_STEP);
        if (goal > now) begin
            if ({1'b0, goal} - {1'b0, now} > step) return now + step[DUTY_W-1:0];
            return goal;
        end
        if ({1'b0, now} - {1'b0, goal} > step) return now - step[DUTY_W-1:0];
        return goal;
    endfunction
`endif

    assign cmd_ready   = (state != ZERO);
    assign atu_monitor = 1'b1;

    // Commands are only looked at outside ZERO, so a held cmd_valid waits for ZERO to finish.
    always_comb begin
        state_next = state;
        zcnt_next  = zcnt;
        reject     = 1'b0;
        set_load   = 1'b0;
        zero_done  = 1'b0;
        if (state == ZERO) begin
            if (zcnt == ZCNT_W'(ZERO_CYCLES - 1)) begin
                state_next = HOLD;
                zero_done  = 1'b1;
            end else begin
                zcnt_next = zcnt + 1'b1;
            end
        end else if (cmd_valid) begin
            unique case (cmd_op)
                OP_SET: begin
                    if ({1'b0, cmd_angle} >= (ANGLE_W+1)'(COUNTS_PER_REV) || cmd_mode[1]) begin
                        reject = 1'b1;
                    end else begin
                        set_load   = 1'b1;
                        state_next = cmd_power ? TRACK : IDLE;
                    end
                end
                OP_ZERO: begin
                    state_next = ZERO;
                    zcnt_next  = '0;
                end
                OP_RUN: begin
                    if (pwm_power) state_next = TRACK;
                    else           reject     = 1'b1;
                end
                OP_BRAKE: state_next = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            zcnt  <= '0;
        end else begin
            state <= state_next;
            zcnt  <= zcnt_next;
        end
    end

    // Stage p0: shortest-path error and control law from the registered target.
    assign err_raw_p0 = $signed({2'b00, target}) - $signed({2'b00, current_angle});

    always_comb begin
        err_p0 = err_raw_p0;
        if (err_raw_p0 > HALF_S)       err_p0 = err_raw_p0 - CPR_S;
        else if (err_raw_p0 < -HALF_S) err_p0 = err_raw_p0 + CPR_S;
        err_abs_p0 = err_p0[ERR_W-1] ? $unsigned(-err_p0) : $unsigned(err_p0);
        fault_p0   = ({1'b0, current_angle} >= (ANGLE_W+1)'(COUNTS_PER_REV));
        in_band_p0 = (err_abs_p0 <= ERR_W'(DEADBAND));
        drive_p0   = (state == TRACK) && (state_next == TRACK) && !fault_p0;
        if (in_band_p0)         law_p0 = '0;
        else if (mode == 2'b00) law_p0 = DUTY_MAX;
        else                    law_p0 = sat_duty(err_abs_p0);
`ifdef SERVO_RAMP_EN
        duty_next_p0 = (drive_p0 && law_p0 != '0) ? ramp_duty(pwm_duty, law_p0) : '0;
`else
        duty_next_p0 = drive_p0 ? law_p0 : '0;
`endif
        if (drive_p0 && in_band_p0 && !set_load)
            scnt_next = (scnt == SCNT_W'(SETTLE_CYCLES)) ? scnt : scnt + 1'b1;
        else
            scnt_next = '0;
    end

    // Stage p1: registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            target     <= '0;
            mode       <= 2'b00;
            pwm_period <= '0;
            pwm_power  <= 1'b0;
            pwm_duty   <= '0;
            pwm_brake  <= 1'b1;
            clockwise  <= 1'b0;
            atu_reset  <= 1'b1;
            at_target  <= 1'b0;
            cmd_error  <= 1'b0;
            busy       <= 1'b0;
            scnt       <= '0;
        end else begin
            if (set_load) begin
                target     <= cmd_angle;
                mode       <= cmd_mode;
                pwm_period <= cmd_period;
                pwm_power  <= cmd_power;
            end else if (zero_done) begin
                target <= '0;
            end
            if (state == TRACK && !fault_p0 && err_p0 != '0) clockwise <= !err_p0[ERR_W-1];
            pwm_duty  <= duty_next_p0;
            pwm_brake <= (state_next != TRACK) || fault_p0;
            atu_reset <= (state_next != ZERO);
            busy      <= (state_next == ZERO);
            cmd_error <= reject;
            scnt      <= scnt_next;
            at_target <= (scnt_next == SCNT_W'(SETTLE_CYCLES));
        end
    end
endmodule

// File: tb/tb_servo_position_controller.sv
// Bench for servo_position_controller: directed vector table, multi-cycle sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_servo_position_controller;
    localparam int CPR = 1006, HALF = CPR / 2, DMAX = 255, KP = 0;
    localparam int DB = 2, SETTLE = 8, ZC = 4;
    localparam int S_IDLE = 0, S_TRACK = 1, S_HOLD = 2, S_ZERO = 3;

    logic        clk = 1'b0, n_reset = 1'b0, cmd_valid = 1'b0, cmd_power = 1'b0;
    logic [1:0]  cmd_op = 2'd0, cmd_mode = 2'd0;
    logic [11:0] cmd_angle = 12'd0, current_angle = 12'd0;
    logic [7:0]  cmd_period = 8'd0;
    logic        cmd_ready, pwm_power, pwm_brake, clockwise, atu_reset, atu_monitor;
    logic        at_target, cmd_error, busy;
    logic [7:0]  pwm_period, pwm_duty;

    int checks = 0, errors = 0;
    int m_state, m_target, m_mode, m_period, m_power, m_duty, m_cw, m_brake;
    int m_atu, m_atgt, m_err, m_busy, m_cnt, m_zleft;

    servo_position_controller #(
        .ANGLE_W(12), .COUNTS_PER_REV(CPR), .DUTY_W(8), .KP_SHIFT(KP), .DEADBAND(DB),
        .SETTLE_CYCLES(SETTLE), .ZERO_CYCLES(ZC), .RAMP_STEP(4)
    ) dut (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_angle(cmd_angle), .cmd_period(cmd_period), .cmd_mode(cmd_mode),
        .cmd_power(cmd_power), .current_angle(current_angle), .pwm_period(pwm_period),
        .pwm_duty(pwm_duty), .pwm_power(pwm_power), .pwm_brake(pwm_brake),
        .clockwise(clockwise), .atu_reset(atu_reset), .atu_monitor(atu_monitor),
        .at_target(at_target), .cmd_error(cmd_error), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Shortest signed distance from current to target on a circle of CPR counts.
    function automatic int wrap_err(input int t, input int c);
        int d;
        d = (t - c) % CPR;
        if (d < 0) d += CPR;
        if (d > HALF) d -= CPR;
        else if (d == HALF && t < c) d = -HALF;
        return d;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_target = 0; m_mode = 0; m_period = 0; m_power = 0; m_duty = 0;
        m_cw = 0; m_brake = 1; m_atu = 1; m_atgt = 0; m_err = 0; m_busy = 0; m_cnt = 0;
        m_zleft = 0;
    endtask

    task automatic model_step();
        int e, ae, law, nst;
        bit fault, inband, drive, rej, setl;
        fault  = int'(current_angle) >= CPR;
        e      = wrap_err(m_target, int'(current_angle));
        ae     = (e < 0) ? -e : e;
        inband = ae <= DB;
        nst = m_state; rej = 0; setl = 0;
        if (m_state == S_ZERO) begin
            m_zleft--;
            if (m_zleft == 0) begin nst = S_HOLD; m_target = 0; end
        end else if (cmd_valid) begin
            case (cmd_op)
                2'd0: if (int'(cmd_angle) >= CPR || cmd_mode >= 2'd2) rej = 1;
                      else begin setl = 1; nst = cmd_power ? S_TRACK : S_IDLE; end
                2'd1: begin nst = S_ZERO; m_zleft = ZC; end
                2'd2: if (m_power != 0) nst = S_TRACK; else rej = 1;
                default: nst = S_HOLD;
            endcase
        end
        drive = (m_state == S_TRACK) && (nst == S_TRACK) && !fault;
        if (inband) law = 0;
        else if (m_mode == 0) law = DMAX;
        else law = ((ae << KP) > DMAX) ? DMAX : (ae << KP);
        m_duty = drive ? law : 0;
        if (m_state == S_TRACK && !fault && e != 0) m_cw = (e > 0) ? 1 : 0;
        m_brake = (nst != S_TRACK || fault) ? 1 : 0;
        m_atu   = (nst != S_ZERO) ? 1 : 0;
        m_busy  = (nst == S_ZERO) ? 1 : 0;
        m_err   = rej;
        if (drive && inband && !setl) m_cnt = (m_cnt >= SETTLE) ? SETTLE : m_cnt + 1;
        else m_cnt = 0;
        m_atgt = (m_cnt == SETTLE) ? 1 : 0;
        if (setl) begin
            m_target = int'(cmd_angle); m_mode = int'(cmd_mode);
            m_period = int'(cmd_period); m_power = int'(cmd_power);
        end
        m_state = nst;
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) model_reset();
        else model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".period"}, int'(pwm_period), m_period);
        check({tag, ".duty"}, int'(pwm_duty), m_duty);
        check({tag, ".power"}, int'(pwm_power), m_power);
        check({tag, ".brake"}, int'(pwm_brake), m_brake);
        check({tag, ".cw"}, int'(clockwise), m_cw);
        check({tag, ".atu_reset"}, int'(atu_reset), m_atu);
        check({tag, ".monitor"}, int'(atu_monitor), 1);
        check({tag, ".at_target"}, int'(at_target), m_atgt);
        check({tag, ".cmd_error"}, int'(cmd_error), m_err);
        check({tag, ".busy"}, int'(busy), m_busy);
        check({tag, ".ready"}, int'(cmd_ready), (m_state != S_ZERO) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input bit v, input int op, input int ang, input int per, input int md,
                       input bit pw, input int cur);
        cmd_valid = v; cmd_op = 2'(op); cmd_angle = 12'(ang); cmd_period = 8'(per);
        cmd_mode = 2'(md); cmd_power = pw; current_angle = 12'(cur);
    endtask

    typedef struct {
        bit v; int op; int ang; int per; int md; bit pw; int cur;
        int duty; int cw; int brake; int power; int period; int err;
    } vec_t;

    vec_t vecs[16];
    int   lowcnt;

    task automatic reset_checks(input string tag);
        check({tag, ".period"}, int'(pwm_period), 0);
        check({tag, ".duty"}, int'(pwm_duty), 0);
        check({tag, ".power"}, int'(pwm_power), 0);
        check({tag, ".brake"}, int'(pwm_brake), 1);
        check({tag, ".cw"}, int'(clockwise), 0);
        check({tag, ".atu_reset"}, int'(atu_reset), 1);
        check({tag, ".at_target"}, int'(at_target), 0);
        check({tag, ".cmd_error"}, int'(cmd_error), 0);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".ready"}, int'(cmd_ready), 1);
        check({tag, ".monitor"}, int'(atu_monitor), 1);
    endtask

    initial begin
        //          v op ang  per md pw cur   duty cw br pw per err
        vecs[0]  = '{1, 0, 100, 200, 1, 1, 40,   0,  0, 0, 1, 200, 0};
        vecs[1]  = '{0, 0, 0,   0,   0, 0, 40,   60, 1, 0, 1, 200, 0};
        vecs[2]  = '{1, 0, 100, 200, 0, 1, 40,   60, 1, 0, 1, 200, 0};
        vecs[3]  = '{0, 0, 0,   0,   0, 0, 40,   255,1, 0, 1, 200, 0};
        vecs[4]  = '{1, 0, 10,  200, 1, 1, 1000, 255,1, 0, 1, 200, 0};
        vecs[5]  = '{0, 0, 0,   0,   0, 0, 1000, 16, 1, 0, 1, 200, 0};
        vecs[6]  = '{1, 0, 1000,200, 1, 1, 10,   0,  1, 0, 1, 200, 0};
        vecs[7]  = '{0, 0, 0,   0,   0, 0, 10,   16, 0, 0, 1, 200, 0};
        vecs[8]  = '{1, 0, 1006,50,  1, 1, 10,   16, 0, 0, 1, 200, 1};
        vecs[9]  = '{1, 0, 500, 50,  2, 1, 10,   16, 0, 0, 1, 200, 1};
        vecs[10] = '{0, 0, 0,   0,   0, 0, 10,   16, 0, 0, 1, 200, 0};
        vecs[11] = '{1, 3, 0,   0,   0, 0, 10,   0,  0, 1, 1, 200, 0};
        vecs[12] = '{1, 2, 0,   0,   0, 0, 10,   0,  0, 0, 1, 200, 0};
        vecs[13] = '{0, 0, 0,   0,   0, 0, 10,   16, 0, 0, 1, 200, 0};
        vecs[14] = '{0, 0, 0,   0,   0, 0, 2000, 0,  0, 1, 1, 200, 0};
        vecs[15] = '{0, 0, 0,   0,   0, 0, 10,   16, 0, 0, 1, 200, 0};

        model_reset();
        repeat (2) tick();
        reset_checks("por");
        n_reset = 1'b1;

        // Asynchronous reset in the middle of a cycle with non-reset outputs.
        cmd(1, 0, 100, 200, 1, 1, 40);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("pre_reset.duty", int'(pwm_duty), 60);
        #2 n_reset = 1'b0;
        #1 reset_checks("async_reset");
        tick();
        n_reset = 1'b1;

        foreach (vecs[i]) begin
            cmd(vecs[i].v, vecs[i].op, vecs[i].ang, vecs[i].per, vecs[i].md, vecs[i].pw,
                vecs[i].cur);
            tick();
            check($sformatf("vec%0d.duty", i), int'(pwm_duty), vecs[i].duty);
            check($sformatf("vec%0d.cw", i), int'(clockwise), vecs[i].cw);
            check($sformatf("vec%0d.brake", i), int'(pwm_brake), vecs[i].brake);
            check($sformatf("vec%0d.power", i), int'(pwm_power), vecs[i].power);
            check($sformatf("vec%0d.period", i), int'(pwm_period), vecs[i].period);
            check($sformatf("vec%0d.err", i), int'(cmd_error), vecs[i].err);
            check_all($sformatf("vec%0d", i));
        end

        // ZERO with a SET queued behind it on a held cmd_valid.
        cmd(1, 1, 0, 0, 0, 0, 10);
        tick();
        cmd(1, 0, 300, 100, 1, 1, 10);
        lowcnt = 0;
        while (atu_reset == 1'b0 && lowcnt < 12) begin
            lowcnt++;
            check("zero.ready", int'(cmd_ready), 0);
            check("zero.busy", int'(busy), 1);
            check("zero.brake", int'(pwm_brake), 1);
            check("zero.duty", int'(pwm_duty), 0);
            tick();
        end
        check("zero.len", lowcnt, ZC);
        check("zero_exit.period", int'(pwm_period), 200);
        check("zero_exit.brake", int'(pwm_brake), 1);
        check_all("zero_exit");
        tick();
        cmd_valid = 1'b0;
        check("queued_set.period", int'(pwm_period), 100);
        check_all("queued_set");
        tick();
        check("queued_set.duty", int'(pwm_duty), 255);
        check("queued_set.cw", int'(clockwise), 1);

        // ZERO with nothing behind it: HOLD with target cleared.
        cmd(1, 1, 0, 0, 0, 0, 10);
        tick();
        cmd_valid = 1'b0;
        repeat (ZC) begin tick(); check_all("zero_only"); end
        check("zero_only.brake", int'(pwm_brake), 1);
        check("zero_only.busy", int'(busy), 0);
        cmd(1, 2, 0, 0, 0, 0, 5);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("zeroed_target.duty", int'(pwm_duty), 5);
        check("zeroed_target.cw", int'(clockwise), 0);

        // Settling inside the deadband, then stepping out of it.
        cmd(1, 0, 300, 100, 1, 1, 301);
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= SETTLE; i++) begin
            tick();
            check($sformatf("settle%0d.at_target", i), int'(at_target), (i == SETTLE) ? 1 : 0);
        end
        current_angle = 12'd305;
        tick();
        check("unsettle.at_target", int'(at_target), 0);
        check("unsettle.duty", int'(pwm_duty), 5);
        check_all("unsettle");

        // Reset while ZERO is in progress.
        cmd(1, 1, 0, 0, 0, 0, 10);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_zero.atu_reset", int'(atu_reset), 0);
        #2 n_reset = 1'b0;
        #1 reset_checks("mid_zero_reset");
        tick();
        n_reset = 1'b1;
        tick();
        check_all("after_mid_zero");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            cmd_valid  = ($urandom_range(0, 7) == 0);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_angle  = ($urandom_range(0, 15) == 0) ? 12'($urandom_range(CPR, 4095))
                                                      : 12'($urandom_range(0, CPR - 1));
            cmd_period = 8'($urandom_range(0, 255));
            cmd_mode   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                     : 2'($urandom_range(0, 1));
            cmd_power  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 19));
                if (r == 0) current_angle = 12'($urandom_range(CPR, 4095));
                else if (r < 12)
                    current_angle = 12'((m_target + CPR + int'($urandom_range(0, 8)) - 4) % CPR);
                else current_angle = 12'($urandom_range(0, CPR - 1));
            end
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
